// File: rtl/mem_bus_ctrl.sv
// MEM-stage bus master: turns one load/store request into a single bus cycle,
// stalls the pipeline while the cycle is open and returns load data.
module mem_bus_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [5:0]  stop_i,
  input  logic        flush_i,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  output logic        stop_req_o,
  output logic [31:0] mem_rdata_o
);

  typedef enum logic [1:0] {IDLE, BUSY, HOLD, ABORT} state_t;

  state_t      state, state_next;
  logic        start, done, capture;
  logic        stop_req;
  logic [31:0] rdata_mux;
  logic [31:0] rdata_q;

  // Only the MEM-held bit of the stall vector matters here; the byte offset
  // is carried by the lane selects rather than the address.
  logic unused;
  assign unused = ^{stop_i[5], stop_i[3:0], mem_addr_i[1:0]};

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    done       = 1'b0;
    capture    = 1'b0;
    stop_req   = 1'b0;
    rdata_mux  = '0;
    case (state)
      IDLE: begin
        if (mem_req_i && !flush_i) begin
          start      = 1'b1;
          stop_req   = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // A flushed access no longer needs the pipeline frozen.
        stop_req = !bus_ack_i && !flush_i;
        if (bus_ack_i) begin
          done = 1'b1;
          if (flush_i) begin
            state_next = IDLE;
          end else begin
            capture    = 1'b1;
            rdata_mux  = bus_we_o ? '0 : bus_rdata_i;
            state_next = stop_i[4] ? HOLD : IDLE;
          end
        end else if (flush_i) begin
          state_next = ABORT;
        end
      end
      HOLD: begin
        rdata_mux = rdata_q;
        if (flush_i || !stop_i[4]) state_next = IDLE;
      end
      ABORT: begin
        // Bus is still owned by the killed access; keep any new one waiting.
        stop_req = mem_req_i && !flush_i;
        if (bus_ack_i) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset overrides the combinational outputs too, so the stage sees a quiet
  // controller for the whole time rst is low.
  assign stop_req_o  = rst && stop_req;
  assign mem_rdata_o = rst ? rdata_mux : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      bus_cyc_o   <= 1'b0;
      bus_stb_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_sel_o   <= '0;
      bus_wdata_o <= '0;
      rdata_q     <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        bus_cyc_o   <= 1'b1;
        bus_stb_o   <= 1'b1;
        bus_we_o    <= mem_we_i;
        bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
        bus_sel_o   <= mem_sel_i;
        bus_wdata_o <= mem_wdata_i;
      end else if (done) begin
        bus_cyc_o <= 1'b0;
        bus_stb_o <= 1'b0;
      end
      if (capture) rdata_q <= rdata_mux;
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Scoreboard bench for mem_bus_ctrl: each issued access queues its expected
// bus/response values; a monitor compares them on every acked bus cycle.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_req_i = 1'b0, mem_we_i = 1'b0;
  logic [31:0] mem_addr_i = '0, mem_wdata_i = '0;
  logic [3:0]  mem_sel_i = '0;
  logic [5:0]  stop_i = '0;
  logic        flush_i = 1'b0;
  logic        bus_ack_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_cyc_o, bus_stb_o, bus_we_o, stop_req_o;
  logic [31:0] bus_addr_o, bus_wdata_o, mem_rdata_o;
  logic [3:0]  bus_sel_o;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  mem_bus_ctrl dut (
    .clk(clk), .rst(rst),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_sel_i(mem_sel_i),
    .stop_i(stop_i), .flush_i(flush_i),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
    .bus_cyc_o(bus_cyc_o), .bus_stb_o(bus_stb_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o), .bus_wdata_o(bus_wdata_o),
    .stop_req_o(stop_req_o), .mem_rdata_o(mem_rdata_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every acked bus cycle must match the oldest queued access.
  always @(negedge clk) begin
    if (rst && bus_cyc_o && bus_ack_i) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_ack: ack at addr 0x%08h with nothing queued", bus_addr_o);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_addr",  bus_addr_o,  mon_e.addr);
        check("sb_we",    bus_we_o,    mon_e.we);
        check("sb_sel",   bus_sel_o,   mon_e.sel);
        check("sb_wdata", bus_wdata_o, mon_e.wdata);
        check("sb_rdata", mem_rdata_o, mon_e.rdata);
      end
    end
  end

  // Issue one access from IDLE at posedge+1; returns at the negedge of the ack cycle.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] sel, input logic [31:0] rdata, input int lat,
                         input logic [5:0] stop_ack, input logic flush_ack);
    exp_t e;
    mem_req_i = 1'b1; mem_we_i = we; mem_addr_i = addr; mem_wdata_i = wdata; mem_sel_i = sel;
    e.addr  = {addr[31:2], 2'b00};
    e.we    = we;
    e.sel   = sel;
    e.wdata = wdata;
    e.rdata = (we || flush_ack) ? 32'h0 : rdata;
    sb_q.push_back(e);
    @(negedge clk);
    check("idle_stall", stop_req_o, 1);
    check("idle_cyc", bus_cyc_o, 0);
    for (int i = 0; i < lat; i++) begin
      tick();
      @(negedge clk);
      check("busy_stall", stop_req_o, 1);
      check("busy_stb", bus_stb_o, 1);
    end
    tick();
    bus_ack_i = 1'b1; bus_rdata_i = rdata; stop_i = stop_ack; flush_i = flush_ack;
    @(negedge clk);
    check("ack_stall", stop_req_o, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values, with a request pending to show the stall is suppressed.
    mem_req_i = 1'b1;
    #12;
    check("rst_cyc", bus_cyc_o, 0);
    check("rst_stb", bus_stb_o, 0);
    check("rst_we", bus_we_o, 0);
    check("rst_addr", bus_addr_o, 0);
    check("rst_sel", bus_sel_o, 0);
    check("rst_wdata", bus_wdata_o, 0);
    check("rst_stall", stop_req_o, 0);
    check("rst_rdata", mem_rdata_o, 0);
    @(posedge clk); #1;
    rst = 1'b1; mem_req_i = 1'b0;

    // Load, unaligned address, ack after three wait cycles.
    run_txn(1'b0, 32'h0000_1006, 32'h0, 4'hF, 32'hDEAD_BEEF, 3, 6'h00, 1'b0);
    check("load_addr", bus_addr_o, 32'h0000_1004);
    check("load_rdata", mem_rdata_o, 32'hDEAD_BEEF);
    tick();
    bus_ack_i = 1'b0; mem_req_i = 1'b0;
    @(negedge clk);
    check("load_done_cyc", bus_cyc_o, 0);
    check("load_done_stall", stop_req_o, 0);

    // Store, then a load requested straight after the ack edge.
    tick();
    run_txn(1'b1, 32'h0000_3000, 32'h1234_5678, 4'h3, 32'hFFFF_FFFF, 1, 6'h00, 1'b0);
    check("store_we", bus_we_o, 1);
    check("store_wdata", bus_wdata_o, 32'h1234_5678);
    check("store_sel", bus_sel_o, 4'h3);
    check("store_rdata", mem_rdata_o, 0);
    tick();
    bus_ack_i = 1'b0;
    run_txn(1'b0, 32'h0000_0FFF, 32'h0, 4'h8, 32'h0BAD_F00D, 2, 6'h00, 1'b0);
    check("b2b_addr", bus_addr_o, 32'h0000_0FFC);
    tick();
    bus_ack_i = 1'b0; mem_req_i = 1'b0;

    // Load acked while MEM is held: two HOLD cycles, stray ack ignored.
    run_txn(1'b0, 32'h0000_2000, 32'h0, 4'hF, 32'hCAFE_F00D, 1, 6'h3F, 1'b0);
    tick();
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_1111;
    @(negedge clk);
    check("hold1_stall", stop_req_o, 0);
    check("hold1_stb", bus_stb_o, 0);
    check("hold1_rdata", mem_rdata_o, 32'hCAFE_F00D);
    tick();
    bus_ack_i = 1'b0; stop_i = 6'h00;
    @(negedge clk);
    check("hold2_stb", bus_stb_o, 0);
    check("hold2_rdata", mem_rdata_o, 32'hCAFE_F00D);
    tick();
    mem_req_i = 1'b0;
    @(negedge clk);
    check("hold_exit_rdata", mem_rdata_o, 0);
    check("hold_exit_cyc", bus_cyc_o, 0);

    // Flush one cycle into BUSY; bus cycle runs to its ack in ABORT.
    tick();
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_4008;
    mem_wdata_i = 32'h0; mem_sel_i = 4'hF;
    sb_q.push_back('{addr: 32'h0000_4008, we: 1'b0, sel: 4'hF, wdata: 32'h0, rdata: 32'h0});
    @(negedge clk);
    check("abort_idle_stall", stop_req_o, 1);
    tick();
    flush_i = 1'b1;
    @(negedge clk);
    check("flush_stall", stop_req_o, 0);
    check("flush_cyc", bus_cyc_o, 1);
    tick();
    flush_i = 1'b0; mem_addr_i = 32'h0000_5000;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("abort_stall", stop_req_o, 1);
      check("abort_cyc", bus_cyc_o, 1);
      check("abort_addr", bus_addr_o, 32'h0000_4008);
      tick();
    end
    bus_ack_i = 1'b1; bus_rdata_i = 32'hBAD0_BAD0;
    @(negedge clk);
    check("abort_ack_stall", stop_req_o, 1);
    tick();
    bus_ack_i = 1'b0;
    run_txn(1'b0, 32'h0000_5000, 32'h0, 4'hF, 32'h55AA_55AA, 0, 6'h00, 1'b0);
    tick();
    bus_ack_i = 1'b0; mem_req_i = 1'b0;

    // Ack and flush together while held: data dropped, no HOLD.
    run_txn(1'b0, 32'h0000_6000, 32'h0, 4'hF, 32'h6666_6666, 1, 6'h3F, 1'b1);
    tick();
    bus_ack_i = 1'b0; flush_i = 1'b0; stop_i = 6'h00; mem_req_i = 1'b0;
    @(negedge clk);
    check("flush_ack_rdata", mem_rdata_o, 0);
    check("flush_ack_stall", stop_req_o, 0);

    // Flush while in HOLD leaves HOLD even though MEM is still held.
    tick();
    run_txn(1'b0, 32'h0000_7000, 32'h0, 4'hF, 32'h7777_7777, 0, 6'h3F, 1'b0);
    tick();
    bus_ack_i = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    check("hold_flush_rdata", mem_rdata_o, 32'h7777_7777);
    tick();
    flush_i = 1'b0; mem_req_i = 1'b0;
    @(negedge clk);
    check("hold_flush_exit", mem_rdata_o, 0);
    tick();
    stop_i = 6'h00;

    // Reset pulse mid-transaction; the late ack must be ignored.
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0000_8000; mem_sel_i = 4'hF;
    @(negedge clk);
    check("rst_txn_stall", stop_req_o, 1);
    tick();
    @(negedge clk);
    check("rst_txn_cyc", bus_cyc_o, 1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("rst_mid_cyc", bus_cyc_o, 0);
    check("rst_mid_stb", bus_stb_o, 0);
    check("rst_mid_stall", stop_req_o, 0);
    check("rst_mid_addr", bus_addr_o, 0);
    @(posedge clk); #1;
    rst = 1'b1; mem_req_i = 1'b0; bus_ack_i = 1'b1; bus_rdata_i = 32'h9999_9999;
    @(negedge clk);
    check("rst_ack_cyc", bus_cyc_o, 0);
    check("rst_ack_rdata", mem_rdata_o, 0);
    check("rst_ack_stall", stop_req_o, 0);
    tick();
    bus_ack_i = 1'b0;
    @(negedge clk);
    check("rst_after_cyc", bus_cyc_o, 0);

    check("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
